// File: rtl/dm_mem_arbiter.sv
// dm_mem_arbiter
//   Shares the single debug-memory slave port between the core's instruction
//   fetch port (read only) and data port (read/write) while the hart executes
//   from debug space. At most one request is accepted per cycle. Memory read
//   data arrives one cycle after the strobe and is steered back to the port
//   that issued it. Each port's last read data is held until its next response.
//
//   Build option: DM_ARB_DATA_PRIO_EN
//     undefined : round-robin between the two ports on a tie
//     defined   : data port always wins a tie (instruction port may starve)
//
//   Ports
//     clk_i, rst_ni                    clock, asynchronous active-low reset
//     i_req_i/i_addr_i                 instruction read request and address
//     i_ready_o                        instruction request accepted this cycle
//     i_rvalid_o/i_rdata_o             instruction read response / held data
//     d_req_i/d_we_i/d_addr_i/
//       d_wdata_i/d_be_i               data request, write enable, addr, data, strobes
//     d_ready_o                        data request accepted this cycle
//     d_rvalid_o/d_rdata_o             data response (read or write) / held data
//     mem_req_o/mem_we_o/mem_addr_o/
//       mem_wdata_o/mem_be_o           debug memory request side
//     mem_rdata_i                      debug memory read data (one cycle latency)
module dm_mem_arbiter #(
    parameter int unsigned BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_req_i,
    input  logic [BusWidth-1:0]   i_addr_i,
    output logic                  i_ready_o,
    output logic                  i_rvalid_o,
    output logic [BusWidth-1:0]   i_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [BusWidth-1:0]   d_addr_i,
    input  logic [BusWidth-1:0]   d_wdata_i,
    input  logic [BusWidth/8-1:0] d_be_i,
    output logic                  d_ready_o,
    output logic                  d_rvalid_o,
    output logic [BusWidth-1:0]   d_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [BusWidth-1:0]   mem_addr_o,
    output logic [BusWidth-1:0]   mem_wdata_o,
    output logic [BusWidth/8-1:0] mem_be_o,
    input  logic [BusWidth-1:0]   mem_rdata_i
);

    // RESP means a response is due in the current cycle
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic                  resp_owner_q, resp_owner_d;  // 0 = I, 1 = D
    logic                  resp_we_q, resp_we_d;        // pending response is a write
    logic [BusWidth-1:0]   i_hold_q, i_hold_d;
    logic [BusWidth-1:0]   d_hold_q, d_hold_d;
`ifndef DM_ARB_DATA_PRIO_EN
    logic                  last_q, last_d;              // last granted port, 0 = I, 1 = D
`endif

    logic gnt_i, gnt_d;
    logic i_rd_resp, d_rd_resp;

    // Grant selection
    always_comb begin
`ifdef DM_ARB_DATA_PRIO_EN
        gnt_d = d_req_i;
`else
        // on a tie the port that was not granted last wins
        gnt_d = d_req_i & (~i_req_i | ~last_q);
`endif
        gnt_i = i_req_i & ~gnt_d;
    end

    assign i_ready_o = gnt_i;
    assign d_ready_o = gnt_d;
    assign mem_req_o = gnt_i | gnt_d;

    // Memory request mux; idle drives zeros
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (gnt_d) begin
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_be_o    = d_be_i;
        end else if (gnt_i) begin
            mem_addr_o  = i_addr_i;
            mem_be_o    = '1;
        end
    end

    // Response routing: live data in the response cycle, held data otherwise.
    // Writes pulse d_rvalid_o but never disturb the held read data.
    assign i_rvalid_o = (state_q == RESP) & ~resp_owner_q;
    assign d_rvalid_o = (state_q == RESP) &  resp_owner_q;
    assign i_rd_resp  = i_rvalid_o;
    assign d_rd_resp  = d_rvalid_o & ~resp_we_q;
    assign i_rdata_o  = i_rd_resp ? mem_rdata_i : i_hold_q;
    assign d_rdata_o  = d_rd_resp ? mem_rdata_i : d_hold_q;

    // Next-state; a new grant may coincide with the current response
    always_comb begin
        state_d      = mem_req_o ? RESP : IDLE;
        resp_owner_d = mem_req_o ? gnt_d : resp_owner_q;
        resp_we_d    = gnt_d & d_we_i;
        i_hold_d     = i_rd_resp ? mem_rdata_i : i_hold_q;
        d_hold_d     = d_rd_resp ? mem_rdata_i : d_hold_q;
`ifndef DM_ARB_DATA_PRIO_EN
        last_d       = mem_req_o ? gnt_d : last_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            resp_owner_q <= 1'b0;
            resp_we_q    <= 1'b0;
            i_hold_q     <= '0;
            d_hold_q     <= '0;
`ifndef DM_ARB_DATA_PRIO_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            resp_owner_q <= resp_owner_d;
            resp_we_q    <= resp_we_d;
            i_hold_q     <= i_hold_d;
            d_hold_q     <= d_hold_d;
`ifndef DM_ARB_DATA_PRIO_EN
            last_q       <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_dm_mem_arbiter.sv
// tb_dm_mem_arbiter
//   Directed testbench for dm_mem_arbiter. Inputs change on the falling edge;
//   outputs are sampled 1 time unit later, well away from the rising edge.
module tb_dm_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_ready_o, i_rvalid_o;
    logic [31:0] i_rdata_o;
    logic        d_req_i, d_we_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_ready_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk_i = ~clk_i;

    dm_mem_arbiter #(.BusWidth(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_req_i     (i_req_i),
        .i_addr_i    (i_addr_i),
        .i_ready_o   (i_ready_o),
        .i_rvalid_o  (i_rvalid_o),
        .i_rdata_o   (i_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_be_i      (d_be_i),
        .d_ready_o   (d_ready_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_req_i     = 1'b0;
        i_addr_i    = '0;
        d_req_i     = 1'b0;
        d_we_i      = 1'b0;
        d_addr_i    = '0;
        d_wdata_i   = '0;
        d_be_i      = '0;
        mem_rdata_i = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // status bits: {i_ready, d_ready, i_rvalid, d_rvalid, mem_req, mem_we}
    function automatic logic [5:0] status();
        return {i_ready_o, d_ready_o, i_rvalid_o, d_rvalid_o, mem_req_o, mem_we_o};
    endfunction

    logic [3:0]  gd;      // expected grant per cycle, 1 = data port
    logic [31:0] ihold;   // expected held instruction data

    initial begin
        rst_ni = 1'b1;
        idle_inputs();

        // ---- reset, idle outputs for three cycles
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i); #1;
            check_eq("idle_status", {26'd0, status()}, 32'd0);
            check_eq("idle_mem", {mem_addr_o | mem_wdata_o}, 32'd0);
            check_eq("idle_be", {28'd0, mem_be_o}, 32'd0);
            check_eq("idle_rdata", i_rdata_o | d_rdata_o, 32'd0);
        end

        // ---- both ports request continuously right after reset
`ifdef DM_ARB_DATA_PRIO_EN
        gd = 4'b1111;
`else
        gd = 4'b1010;     // I, D, I, D
`endif
        ihold = 32'd0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk_i);
            i_req_i     = (k < 4);
            d_req_i     = (k < 4);
            d_we_i      = 1'b1;
            i_addr_i    = 32'h100;
            d_addr_i    = 32'h200;
            d_be_i      = 4'hF;
            d_wdata_i   = 32'hC0 + k;
            mem_rdata_i = 32'hA0 + k;
            #1;
            if (k < 4) begin
                check_eq("rr_i_ready", i_ready_o, !gd[k]);
                check_eq("rr_d_ready", d_ready_o, gd[k]);
                check_eq("rr_mem_we", mem_we_o, gd[k]);
                check_eq("rr_mem_addr", mem_addr_o, gd[k] ? 32'h200 : 32'h100);
            end else begin
                check_eq("rr_mem_req_end", mem_req_o, 1'b0);
            end
            if (k > 0) begin
                if (!gd[k-1]) ihold = 32'hA0 + k;
                check_eq("rr_i_rvalid", i_rvalid_o, !gd[k-1]);
                check_eq("rr_d_rvalid", d_rvalid_o, gd[k-1]);
                check_eq("rr_i_rdata", i_rdata_o, ihold);
                check_eq("rr_d_rdata", d_rdata_o, 32'd0);
            end else begin
                check_eq("rr_no_rvalid0", {i_rvalid_o, d_rvalid_o}, 32'd0);
            end
        end

        // ---- single instruction fetch
        apply_reset();
        @(negedge clk_i);
        i_req_i = 1'b1; i_addr_i = 32'h800; #1;
        check_eq("if_status", {26'd0, status()}, {26'd0, 6'b100010});
        check_eq("if_addr", mem_addr_o, 32'h800);
        check_eq("if_be", {28'd0, mem_be_o}, 32'hF);
        @(negedge clk_i);
        i_req_i = 1'b0; i_addr_i = '0; mem_rdata_i = 32'h0000_006F; #1;
        check_eq("if_rvalid", {i_rvalid_o, d_rvalid_o}, 32'b10);
        check_eq("if_rdata", i_rdata_o, 32'h6F);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            mem_rdata_i = 32'hFFFF_FFFF; #1;
            check_eq("if_rvalid_drop", i_rvalid_o, 1'b0);
            check_eq("if_rdata_held", i_rdata_o, 32'h6F);
        end

        // ---- data read 0x1234 then write 0xDEADBEEF be=0011 to 0x380
        @(negedge clk_i);
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h380; d_be_i = 4'hF; #1;
        check_eq("dr_ready", d_ready_o, 1'b1);
        check_eq("dr_we", mem_we_o, 1'b0);
        @(negedge clk_i);
        d_we_i = 1'b1; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011; mem_rdata_i = 32'h1234; #1;
        check_eq("dr_rvalid", d_rvalid_o, 1'b1);
        check_eq("dr_rdata", d_rdata_o, 32'h1234);
        check_eq("dw_mem_we", mem_we_o, 1'b1);
        check_eq("dw_mem_be", {28'd0, mem_be_o}, 32'h3);
        check_eq("dw_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        check_eq("dw_mem_addr", mem_addr_o, 32'h380);
        @(negedge clk_i);
        idle_inputs(); mem_rdata_i = 32'h5555_5555; #1;
        check_eq("dw_rvalid", d_rvalid_o, 1'b1);
        check_eq("dw_rdata_kept", d_rdata_o, 32'h1234);
        @(negedge clk_i); #1;
        check_eq("dw_rvalid_drop", d_rvalid_o, 1'b0);
        check_eq("dw_rdata_held", d_rdata_o, 32'h1234);
        check_eq("dw_i_rdata_held", i_rdata_o, 32'h6F);

        // ---- instruction request dropped after losing to the data port
        @(negedge clk_i);
        i_req_i = 1'b1; i_addr_i = 32'h804; mem_rdata_i = 32'h0; #1;
        check_eq("drop_pre_i_ready", i_ready_o, 1'b1);
        @(negedge clk_i);
        i_addr_i = 32'h808; d_req_i = 1'b1; d_addr_i = 32'h3A0; d_be_i = 4'hF;
        mem_rdata_i = 32'h13; #1;
        check_eq("drop_i_ready", i_ready_o, 1'b0);
        check_eq("drop_d_ready", d_ready_o, 1'b1);
        check_eq("drop_mem_addr", mem_addr_o, 32'h3A0);
        check_eq("drop_prev_i_rvalid", i_rvalid_o, 1'b1);
        @(negedge clk_i);
        idle_inputs(); mem_rdata_i = 32'h77; #1;
        check_eq("drop_mem_req", mem_req_o, 1'b0);
        check_eq("drop_rvalid", {i_rvalid_o, d_rvalid_o}, 32'b01);
        check_eq("drop_d_rdata", d_rdata_o, 32'h77);
        @(negedge clk_i); #1;
        check_eq("drop_i_rvalid_after", i_rvalid_o, 1'b0);
        check_eq("drop_i_rdata", i_rdata_o, 32'h13);

        // ---- reset asserted while a data read response is due
        @(negedge clk_i);
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h390; d_be_i = 4'hF; #1;
        check_eq("rst_d_ready", d_ready_o, 1'b1);
        @(negedge clk_i);
        idle_inputs(); mem_rdata_i = 32'h9999; rst_ni = 1'b0; #1;
        check_eq("rst_rvalid_async", {i_rvalid_o, d_rvalid_o}, 32'd0);
        check_eq("rst_d_rdata", d_rdata_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1; #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i); #1;
            check_eq("rst_no_rvalid", {i_rvalid_o, d_rvalid_o}, 32'd0);
            check_eq("rst_hold_zero", d_rdata_o | i_rdata_o, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
